led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
- Parametrised LED pattern engine for the board-level demo designs; successor to the fixed 8-LED blink/toggle controller.
- Two raw push-buttons are debounced internally: MODE cycles through four display modes, ACTION acts within the current mode.
- Pattern steps are paced by an internal millisecond-based tick; the registered LED bus drives the board LEDs directly, with configurable polarity.

Parameters:
- NUM_LEDS, 8, number of LEDs; even, >= 2
- CLK_FREQ_HZ, 10_000_000, system clock frequency
- STEP_MS, 250, pattern step period in ms
- DEBOUNCE_MS, 10, button stable time in ms
- BTN_ACTIVE_LOW, 0, 1 = button reads 0 when pressed (pull-up wiring)
- LED_ACTIVE_LOW, 1, 1 = LED lit when its output bit is 0
- PWM_DUTY, 8, lit duty in 1/16 steps, 1..16; used only with LED_PWM_EN

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_mode  in  1  raw mode button
- btn_action  in  1  raw action button
- led_out  out  NUM_LEDS  LED drive, registered
- mode  out  2  current mode, registered
- step_tick  out  1  one-cycle pulse per pattern step

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst is high:
  - mode = 0; all LEDs off (led_out = all ones if LED_ACTIVE_LOW, else all zeros).
  - step_tick = 0; all counters, pattern state and debounce state cleared.
- Reset asserted mid-step or mid-debounce aborts the step or debounce immediately; no press is reported after release of rst.
- Tick generator:
  - TICKS = CLK_FREQ_HZ/1000*STEP_MS (must be >= 1); counter width $clog2(TICKS).
  - step_tick pulses for one cycle when the counter equals TICKS-1; the counter then wraps to 0.
- Mode FSM, states MODE_HALF(0), MODE_CHASE(1), MODE_TOGGLE(2), MODE_BINARY(3):
  - A mode press advances to the next state; 3 wraps to 0.
  - On a mode change, the tick counter, position, direction, phase, binary count and toggle state all clear in the same cycle.
  - A mode press and an action press in the same cycle: the mode press wins and the action press is dropped.
- MODE_HALF:
  - phase flips on each tick.
  - phase 0: lower half (bits NUM_LEDS/2-1..0) lit; phase 1: upper half lit.
- MODE_CHASE:
  - Exactly one LED lit, at position pos; ping-pong sequence 0,1,..,N-1,N-2,..,1,0,1...
  - Direction reverses on arrival at 0 or N-1; no LED is repeated at an end.
  - An action press freezes/unfreezes stepping; the tick counter keeps running while frozen.
- MODE_TOGGLE:
  - An action press toggles all LEDs between on and off; initial state is off. Ticks are ignored.
- MODE_BINARY:
  - A NUM_LEDS-bit count increments on each tick and wraps from all-ones to 0; bit i lit iff count[i] = 1.
  - An action press clears the count to 0.
- Output timing:
  - led_out and mode update the cycle after the causing tick or press pulse.
  - Press pulse to mode visible: 1 cycle after the pulse.
- Debounce (per button):
  - 2-flop synchroniser, then the input is inverted if BTN_ACTIVE_LOW.
  - The stable level updates after the synchronised input holds the same value for DEBOUNCE_MS*CLK_FREQ_HZ/1000 consecutive cycles; any change restarts the count.
  - One press pulse, one cycle wide, on each stable 0->1 transition. A held button gives exactly one pulse.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - A free-running 4-bit PWM counter; lit LEDs are driven on only while pwm_cnt < PWM_DUTY; off LEDs stay off.
  - The PWM counter clears on reset only.
- Undefined: lit LEDs are driven continuously; PWM_DUTY is ignored and no PWM logic is generated.

Decomposition:
- Package led_pattern_pkg:
  - mode enum type mode_t (2-bit) with the four state names.
  - PWM_BITS = 4.
- Sub-module btn_debounce:
  - Parameters CLK_FREQ_HZ, DEBOUNCE_MS, BTN_ACTIVE_LOW.
  - Ports clk, rst, btn_raw, btn_level, btn_press.
  - Instantiated twice.
- Tick generator, mode FSM and pattern logic stay in the top module.

Test Plan (NUM_LEDS=8, CLK_FREQ_HZ=4000, STEP_MS=1 -> 4 cycles/step, DEBOUNCE_MS=1 -> 4 cycles, LED_ACTIVE_LOW=1):
- Reset then idle 9 cycles -> led_out = 8'hFF during reset, then 8'hF0 / 8'h0F alternating every 4 cycles (phase 0 = 8'hF0, lower half lit); mode = 0.
- Bouncy mode press (toggle 1/0 every 2 cycles, then hold high 20 cycles) -> exactly one press pulse; mode = 1; chase led_out sequence FE,FD,FB,..,7F,BF,..,FE.
- Mode = 2; action press twice -> led_out 8'hFF -> 8'h00 -> 8'hFF; step_tick keeps pulsing with no LED change.
- Mode = 3; run 256 steps -> count wraps to 0, led_out back to 8'hFF; action press at count 5 -> led_out 8'hFF next cycle.
- Mode and action press pulses in the same cycle while in mode 2 -> mode becomes 3, toggle state is not flipped; rst pulsed mid-chase -> immediate mode 0, led_out 8'hFF.
- With LED_PWM_EN, PWM_DUTY=4, mode 2 on -> each lit LED is low 4 of every 16 cycles.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern controller.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_HALF   = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_BINARY = 2'd3
    } mode_t;

    localparam int PWM_BITS = 4;

endpackage

// File: rtl/led_pattern_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, polarity fix-up, stable-time
// debounce and a single-cycle press pulse on each stable 0->1 transition.
module btn_debounce #(
    parameter int CLK_FREQ_HZ    = 10_000_000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int BTN_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    localparam int DB_RAW    = DEBOUNCE_MS * CLK_FREQ_HZ / 1000;
    localparam int DB_CYCLES = (DB_RAW > 0) ? DB_RAW : 1;
    localparam int CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic IDLE_RAW = (BTN_ACTIVE_LOW != 0);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             btn_in;

    assign btn_in    = sync_q[1] ^ IDLE_RAW;
    assign btn_level = level_q;
    assign btn_press = press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: synchroniser resets to the released raw level so a pull-up
            // button is not seen as pressed on the first cycles after reset.
            sync_q  <= {2{IDLE_RAW}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            sync_q  <= {sync_q[0], btn_raw};
            press_q <= 1'b0;
            if (btn_in == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                level_q <= btn_in;
                press_q <= btn_in;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: four button-selected display modes paced by a step tick.
// Define LED_PWM_EN to dim lit LEDs with a 4-bit PWM (duty PWM_DUTY/16).
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int CLK_FREQ_HZ    = 10_000_000,
    parameter int STEP_MS        = 250,
    parameter int DEBOUNCE_MS    = 10,
    parameter int BTN_ACTIVE_LOW = 0,
    parameter int LED_ACTIVE_LOW = 1,
    parameter int PWM_DUTY       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_action,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [1:0]          mode,
    output logic                step_tick
);
    localparam int TICKS  = CLK_FREQ_HZ / 1000 * STEP_MS;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS - 1);
    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LOWER_HALF =
        {{(NUM_LEDS/2){1'b0}}, {(NUM_LEDS/2){1'b1}}};
    localparam logic [NUM_LEDS-1:0] LED_POLARITY = {NUM_LEDS{LED_ACTIVE_LOW != 0}};

    logic mode_press, action_press;
    logic unused_mode_level, unused_action_level;
    logic pwm_on;

    mode_t               mode_q, mode_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                phase_q, phase_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_down_q, dir_down_d;
    logic                frozen_q, frozen_d;
    logic                toggle_q, toggle_d;
    logic [NUM_LEDS-1:0] count_q, count_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] lit;

    btn_debounce #(
        .CLK_FREQ_HZ   (CLK_FREQ_HZ),
        .DEBOUNCE_MS   (DEBOUNCE_MS),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_db_mode (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_mode),
        .btn_level(unused_mode_level),
        .btn_press(mode_press)
    );

    btn_debounce #(
        .CLK_FREQ_HZ   (CLK_FREQ_HZ),
        .DEBOUNCE_MS   (DEBOUNCE_MS),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_db_action (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_action),
        .btn_level(unused_action_level),
        .btn_press(action_press)
    );

`ifdef LED_PWM_EN
    localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(PWM_DUTY);
    logic [PWM_BITS-1:0] pwm_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end

    assign pwm_on = ({1'b0, pwm_cnt_q} < DUTY);
`else
    assign pwm_on = 1'b1;
`endif

    assign step_tick = (tick_cnt_q == TICK_MAX);
    assign led_out   = led_q;
    assign mode      = mode_q;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path
        // through the case statement can leave a latch behind.
        mode_d     = mode_q;
        tick_cnt_d = step_tick ? '0 : tick_cnt_q + TICK_W'(1);
        phase_d    = phase_q;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        frozen_d   = frozen_q;
        toggle_d   = toggle_q;
        count_d    = count_q;

        if (mode_press) begin
            // A mode change restarts every pattern from a clean state; a
            // coincident action press is intentionally dropped.
            mode_d     = mode_t'(mode_q + 2'd1);
            tick_cnt_d = '0;
            phase_d    = 1'b0;
            pos_d      = '0;
            dir_down_d = 1'b0;
            frozen_d   = 1'b0;
            toggle_d   = 1'b0;
            count_d    = '0;
        end else begin
            case (mode_q)
                MODE_HALF: if (step_tick) phase_d = ~phase_q;
                MODE_CHASE: begin
                    if (action_press) frozen_d = ~frozen_q;
                    if (step_tick && !frozen_q) begin
                        if (!dir_down_q) begin
                            if (pos_q == POS_MAX) begin
                                pos_d      = pos_q - POS_W'(1);
                                dir_down_d = 1'b1;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d      = pos_q + POS_W'(1);
                                dir_down_d = 1'b0;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                    end
                end
                MODE_TOGGLE: if (action_press) toggle_d = ~toggle_q;
                MODE_BINARY: begin
                    if (action_press)   count_d = '0;
                    else if (step_tick) count_d = count_q + NUM_LEDS'(1);
                end
                default: ;
            endcase
        end

        lit = '0;
        case (mode_d)
            MODE_HALF:   lit = phase_d ? ~LOWER_HALF : LOWER_HALF;
            MODE_CHASE:  lit[pos_d] = 1'b1;
            MODE_TOGGLE: lit = {NUM_LEDS{toggle_d}};
            MODE_BINARY: lit = count_d;
            default:     lit = '0;
        endcase
        led_d = (lit & {NUM_LEDS{pwm_on}}) ^ LED_POLARITY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_HALF;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            frozen_q   <= 1'b0;
            toggle_q   <= 1'b0;
            count_q    <= '0;
            led_q      <= LED_POLARITY;
        end else begin
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            frozen_q   <= frozen_d;
            toggle_q   <= toggle_d;
            count_q    <= count_d;
            led_q      <= led_d;
        end
    end

endmodule
